// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types, prefix constants and the key codes used by the adjust counters.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_INC   = 8'h73;
    localparam logic [7:0] SC_SEL   = 8'h6C;

    // Eight data bits plus the parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises both PS/2 lines, debounces the clock and flags its filtered falling edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [FILTER_LEN-1:0] hist;
    logic [FILTER_LEN-1:0] hist_n;
    logic                  filt;

    assign hist_n = {hist[FILTER_LEN-2:0], clk_sync[1]};
    assign data_s = dat_sync[1];

    // Filtered clock only moves once the whole history agrees on a level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            hist     <= '1;
            filt     <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            hist     <= hist_n;
            fall     <= filt && (hist_n == '0);
            if (hist_n == '0) begin
                filt <= 1'b0;
            end else if (hist_n == '1) begin
                filt <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 frame receiver: deserialises, checks frames, strips F0/E0 prefixes and strobes make codes.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       got_data,
    output logic       extended,
    output logic       frame_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic fall;
    logic data_s;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data_s   (data_s)
    );

    ps2_state_t      state, state_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      shreg, shreg_n;
    logic            par_ok, par_ok_n;
    logic [WD_W-1:0] wd_cnt, wd_cnt_n;
    logic            brk_pend, brk_pend_n;
    logic            ext_pend, ext_pend_n;
    logic [7:0]      scan_code_n;
    logic            extended_n;
    logic            got_data_n;
    logic            frame_err_n;
    logic            byte_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_ok    <= 1'b0;
            wd_cnt    <= '0;
            brk_pend  <= 1'b0;
            ext_pend  <= 1'b0;
            scan_code <= '0;
            extended  <= 1'b0;
            got_data  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            par_ok    <= par_ok_n;
            wd_cnt    <= wd_cnt_n;
            brk_pend  <= brk_pend_n;
            ext_pend  <= ext_pend_n;
            scan_code <= scan_code_n;
            extended  <= extended_n;
            got_data  <= got_data_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        par_ok_n    = par_ok;
        wd_cnt_n    = '0;
        brk_pend_n  = brk_pend;
        ext_pend_n  = ext_pend;
        scan_code_n = scan_code;
        extended_n  = extended;
        got_data_n  = 1'b0;
        frame_err_n = 1'b0;
        byte_done   = 1'b0;

        // Watchdog: a sample event always wins over an expiring count.
        if (state != ST_IDLE && !fall) begin
            if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                frame_err_n = 1'b1;
                state_n     = ST_IDLE;
                brk_pend_n  = 1'b0;
                ext_pend_n  = 1'b0;
            end else begin
                wd_cnt_n = wd_cnt + WD_W'(1);
            end
        end

        if (fall) begin
            unique case (state)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                    end
                end
                ST_DATA: begin
                    shreg_n   = {data_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_ok_n = odd_parity_ok(shreg, data_s);
                    state_n  = ST_STOP;
                end
                ST_STOP: begin
                    if (data_s && par_ok) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                        brk_pend_n  = 1'b0;
                        ext_pend_n  = 1'b0;
                    end
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end

        // Prefix handling: only an unbroken make code reaches the outputs.
        if (byte_done) begin
            if (shreg == SC_BREAK) begin
                brk_pend_n = 1'b1;
            end else if (shreg == SC_EXT) begin
                ext_pend_n = 1'b1;
            end else begin
                if (!brk_pend) begin
                    scan_code_n = shreg;
                    extended_n  = ext_pend;
                    got_data_n  = 1'b1;
                end
                brk_pend_n = 1'b0;
                ext_pend_n = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised scoreboard bench for ps2_scancode_rx against a frame-level reference model.
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int unsigned FL   = 8;
    localparam int unsigned TO   = 400;
    localparam int unsigned HALF = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       got_data;
    logic       extended;
    logic       frame_err;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scan_code (scan_code),
        .got_data  (got_data),
        .extended  (extended),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_ev;
    int         checks = 0;
    int         passed = 0;
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;
    logic [7:0] m_code = 8'h00;
    logic       m_code_ext = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Reference behaviour of one received byte, expressed as the prefix rules.
    task automatic model_byte(input logic [7:0] b);
        if (b == SC_BREAK) m_brk = 1'b1;
        else if (b == SC_EXT) m_ext = 1'b1;
        else begin
            if (!m_brk) begin
                exp_q.push_back('{is_err: 1'b0, ext: m_ext, code: b});
                m_code     = b;
                m_code_ext = m_ext;
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic model_err();
        exp_q.push_back('{is_err: 1'b1, ext: 1'b0, code: 8'h00});
        m_brk = 1'b0;
        m_ext = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF / 2) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (HALF / 2) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        if (bad_par || bad_stop) model_err();
        else model_byte(b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    // Start bit plus n data bits, then the clock stays idle.
    task automatic send_partial(input int n, input logic expect_err);
        logic [7:0] b;
        b = 8'($urandom);
        if (expect_err) model_err();
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    task automatic check_hold(input string tag);
        check({tag, " scan_code"}, 32'(scan_code), 32'(m_code));
        check({tag, " extended"}, 32'(extended), 32'(m_code_ext));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (got_data && frame_err) check("strobe exclusive", 32'd1, 32'd0);
            if (got_data || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected event", {30'd0, got_data, frame_err}, 32'd0);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("event kind", 32'(frame_err), 32'(mon_ev.is_err));
                    if (!mon_ev.is_err) begin
                        check("event scan_code", 32'(scan_code), 32'(mon_ev.code));
                        check("event extended", 32'(extended), 32'(mon_ev.ext));
                    end
                end
            end
        end
    end

    initial begin
        int r;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset scan_code", 32'(scan_code), 32'd0);
        check("reset got_data", 32'(got_data), 32'd0);
        check("reset extended", 32'(extended), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        send_frame(SC_INC, 1'b0, 1'b0);
        check_hold("clean");
        send_frame(SC_EXT, 1'b0, 1'b0);
        send_frame(SC_DOWN, 1'b0, 1'b0);
        check_hold("extended key");
        send_frame(SC_INC, 1'b0, 1'b0);
        send_frame(SC_BREAK, 1'b0, 1'b0);
        send_frame(SC_INC, 1'b0, 1'b0);
        check_hold("release");
        send_frame(SC_EXT, 1'b0, 1'b0);
        send_frame(SC_BREAK, 1'b0, 1'b0);
        send_frame(SC_UP, 1'b0, 1'b0);
        check_hold("extended release");

        send_frame(SC_SEL, 1'b1, 1'b0);
        send_frame(SC_BREAK, 1'b0, 1'b0);
        send_frame(SC_SEL, 1'b1, 1'b0);
        send_frame(SC_SEL, 1'b0, 1'b0);
        check_hold("error clears break");
        send_frame(SC_UP, 1'b0, 1'b1);
        check_hold("bad stop");

        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        send_frame(SC_EXT, 1'b0, 1'b0);
        send_partial(4, 1'b1);
        repeat (TO + 100) @(posedge clk);
        send_frame(SC_UP, 1'b0, 1'b0);
        check_hold("after timeout");

        for (int i = 0; i < 20; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0: send_frame(SC_BREAK, 1'b0, 1'b0);
                1: send_frame(SC_EXT, 1'b0, 1'b0);
                2: send_frame(8'($urandom), 1'b1, 1'b0);
                default: send_frame(8'($urandom), 1'b0, 1'b0);
            endcase
        end
        check_hold("random");

        send_partial(5, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midframe rst scan_code", 32'(scan_code), 32'd0);
        check("midframe rst got_data", 32'(got_data), 32'd0);
        check("midframe rst extended", 32'(extended), 32'd0);
        check("midframe rst frame_err", 32'(frame_err), 32'd0);
        m_brk      = 1'b0;
        m_ext      = 1'b0;
        m_code     = 8'h00;
        m_code_ext = 1'b0;
        rst = 1'b0;
        repeat (HALF) @(posedge clk);
        check_hold("after reset");
        send_frame(SC_SEL, 1'b0, 1'b0);
        check_hold("recovery");

        repeat (200) @(posedge clk);
        check("pending events", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
